sampletest_multi: RTL and testbench

- Parametrised successor to the single-sample edge-equation tester.
- Tests LANES sample locations per cycle against one triangle. Selectable face culling: none, back or front.
- Pipelined over PIPE_DEPTH stages with valid/ready backpressure. Keeps a saturating hit counter for profiling.
- Sits between the sample iterator (R16) and the hash/z-buffer stage (R16+PIPE_DEPTH).

---
 rtl/sampletest_multi.sv | 165 ++++++++++++++++
 tb/tb_sampletest_multi.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sampletest_multi.sv
// Multi-lane edge-equation sample tester: LANES samples per beat against one triangle,
// selectable face culling, PIPE_DEPTH-stage valid/ready pipeline, saturating hit counter.
module sampletest_multi #(
  parameter int SIGFIG     = 24,
  parameter int RADIX      = 10,
  parameter int LANES      = 4,
  parameter int COLORS     = 3,
  parameter int IGNORE     = 8,
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [2:0][2:0][SIGFIG-1:0]            tri_i,
  input  logic [COLORS-1:0][SIGFIG-1:0]          color_i,
  input  logic [LANES-1:0][1:0][SIGFIG-1:0]      sample_i,
  input  logic [LANES-1:0]                       samp_valid_i,
  input  logic [1:0]                             cull_mode_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  output logic [LANES-1:0][2:0][SIGFIG-1:0]      hit_o,
  output logic [COLORS-1:0][SIGFIG-1:0]          color_o,
  output logic [LANES-1:0]                       hit_mask_o,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  input  logic                                   clr_cnt_i,
  output logic [CNT_W-1:0]                       hit_count_o
);

  localparam int SHORTSF = SIGFIG - IGNORE;
  localparam int DW      = 2 * SHORTSF;
  localparam int PCW     = $clog2(LANES + 1);
  localparam int CW1     = CNT_W + 1;

  if (PIPE_DEPTH < 1 || RADIX >= SHORTSF) begin : g_param_check
    $error("sampletest_multi: PIPE_DEPTH must be >= 1 and RADIX < SIGFIG-IGNORE");
  end

  function automatic logic signed [SHORTSF-1:0] trunc_f(input logic [SIGFIG-1:0] v);
    return {v[SIGFIG-1], v[SHORTSF-2:0]};
  endfunction

  function automatic logic signed [DW-1:0] edge_f(
    input logic signed [SHORTSF-1:0] xa, input logic signed [SHORTSF-1:0] ya,
    input logic signed [SHORTSF-1:0] xb, input logic signed [SHORTSF-1:0] yb);
    logic signed [DW-1:0] p;
    logic signed [DW-1:0] q;
    p = DW'(xa) * DW'(yb);
    q = DW'(xb) * DW'(ya);
    return p - q;
  endfunction

  // d1 is strict in both windings, so a degenerate triangle never hits
  function automatic logic inside_f(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                    input logic [DW-1:0] d2, input logic [1:0] mode);
    logic back_v;
    logic front_v;
    logic res_v;
    back_v  = (d0[DW-1] || (d0 == '0)) && d1[DW-1] && (d2[DW-1] || (d2 == '0));
    front_v = !d0[DW-1] && !d1[DW-1] && (d1 != '0) && !d2[DW-1];
    case (mode)
      2'd0:    res_v = back_v || front_v;
      2'd2:    res_v = front_v;
      default: res_v = back_v;
    endcase
    return res_v;
  endfunction

  logic                                  adv_s;
  logic                                  accept_s;
  logic [LANES-1:0]                      inside_s;
  logic [LANES-1:0][2:0][SIGFIG-1:0]     hit_s;
  logic                                  unused_z_s;

  assign adv_s      = !out_valid_o || out_ready_i;
  assign in_ready_o = adv_s;
  assign accept_s   = in_valid_i && adv_s;
  assign unused_z_s = ^{tri_i[1][2], tri_i[2][2]};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [SHORTSF-1:0] vx_s [3];
    logic signed [SHORTSF-1:0] vy_s [3];
    logic signed [DW-1:0]      d_s  [3];
    for (genvar v = 0; v < 3; v++) begin : g_vtx
      assign vx_s[v] = trunc_f(tri_i[v][0] - sample_i[l][0]);
      assign vy_s[v] = trunc_f(tri_i[v][1] - sample_i[l][1]);
    end
    for (genvar k = 0; k < 3; k++) begin : g_edge
      assign d_s[k] = edge_f(vx_s[k], vy_s[k], vx_s[(k+1)%3], vy_s[(k+1)%3]);
    end
    assign inside_s[l] = inside_f(d_s[0], d_s[1], d_s[2], cull_mode_i) && samp_valid_i[l];
    assign hit_s[l]    = {tri_i[0][2], sample_i[l][1], sample_i[l][0]};
  end

  logic [PIPE_DEPTH-1:0]               vld_r;
  logic [LANES-1:0]                    mask_r [PIPE_DEPTH];
  logic [LANES-1:0][2:0][SIGFIG-1:0]   hit_r  [PIPE_DEPTH];
  logic [COLORS-1:0][SIGFIG-1:0]       col_r  [PIPE_DEPTH];

  // Lock-step pipeline; bubbles carry zeroed data so idle stages hold no stale beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        mask_r[i] <= '0;
        hit_r[i]  <= '0;
        col_r[i]  <= '0;
      end
    end else if (adv_s) begin
      vld_r[0] <= accept_s;
      if (accept_s) begin
        mask_r[0] <= inside_s;
        hit_r[0]  <= hit_s;
        col_r[0]  <= color_i;
      end else begin
        mask_r[0] <= '0;
        hit_r[0]  <= '0;
        col_r[0]  <= '0;
      end
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        vld_r[i]  <= vld_r[i-1];
        mask_r[i] <= mask_r[i-1];
        hit_r[i]  <= hit_r[i-1];
        col_r[i]  <= col_r[i-1];
      end
    end else begin
      vld_r <= vld_r;
    end
  end

  assign out_valid_o = vld_r[PIPE_DEPTH-1];
  assign hit_mask_o  = mask_r[PIPE_DEPTH-1];
  assign hit_o       = hit_r[PIPE_DEPTH-1];
  assign color_o     = col_r[PIPE_DEPTH-1];

  logic [PCW-1:0]   pop_s;
  logic [CW1-1:0]   sum_s;
  logic [CNT_W-1:0] cnt_r;

  // Number of hits in the beat currently presented at the output
  always_comb begin
    pop_s = '0;
    for (int l = 0; l < LANES; l++) begin
      pop_s = pop_s + PCW'(hit_mask_o[l]);
    end
  end

  assign sum_s = {1'b0, cnt_r} + CW1'(pop_s);

  // Saturating hit counter; clear has priority over a same-cycle handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clr_cnt_i) begin
      cnt_r <= '0;
    end else if (out_valid_o && out_ready_i) begin
      cnt_r <= sum_s[CNT_W] ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hit_count_o = cnt_r;

endmodule

// File: tb/tb_sampletest_multi.sv
// Scoreboard bench for sampletest_multi: an independent edge model predicts each beat,
// a second instance with a 4-bit counter covers saturation.
module tb_sampletest_multi;
  localparam int SIGFIG  = 24;
  localparam int LANES   = 4;
  localparam int COLORS  = 3;
  localparam int SHORTSF = 16;

  typedef logic [2:0][2:0][SIGFIG-1:0]       tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]     col_t;
  typedef logic [LANES-1:0][1:0][SIGFIG-1:0] smp_t;
  typedef logic [LANES-1:0][2:0][SIGFIG-1:0] hit_t;
  typedef struct { logic [LANES-1:0] mask; hit_t hit; col_t col; } exp_t;

  logic clk = 1'b0;
  logic rst;
  tri_t tri_i;
  col_t color_i;
  smp_t sample_i;
  logic [LANES-1:0] samp_valid_i;
  logic [1:0] cull_mode_i;
  logic in_valid_i, out_ready_i, clr_cnt_i;
  logic in_ready_o, out_valid_o;
  hit_t hit_o;
  col_t color_o;
  logic [LANES-1:0] hit_mask_o;
  logic [31:0] hit_count_o;
  logic in_ready_c4, out_valid_c4;
  hit_t hit_c4;
  col_t color_c4;
  logic [LANES-1:0] hit_mask_c4;
  logic [3:0] hit_count_c4;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];
  exp_t ev;
  longint cnt_m = 0;
  int cnt4_m = 0;
  logic hold_prev = 1'b0;
  logic [511:0] hold_val;

  sampletest_multi u_dut (
    .clk(clk), .rst(rst), .tri_i(tri_i), .color_i(color_i), .sample_i(sample_i),
    .samp_valid_i(samp_valid_i), .cull_mode_i(cull_mode_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .hit_o(hit_o), .color_o(color_o), .hit_mask_o(hit_mask_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .clr_cnt_i(clr_cnt_i),
    .hit_count_o(hit_count_o));

  sampletest_multi #(.CNT_W(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .tri_i(tri_i), .color_i(color_i), .sample_i(sample_i),
    .samp_valid_i(samp_valid_i), .cull_mode_i(cull_mode_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_c4), .hit_o(hit_c4), .color_o(color_c4), .hit_mask_o(hit_mask_c4),
    .out_valid_o(out_valid_c4), .out_ready_i(out_ready_i), .clr_cnt_i(clr_cnt_i),
    .hit_count_o(hit_count_c4));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int trn(input logic [SIGFIG-1:0] v);
    int r;
    r = int'(v[SHORTSF-2:0]);
    if (v[SIGFIG-1]) r = r - (2 ** (SHORTSF - 1));
    return r;
  endfunction

  function automatic logic [LANES-1:0] exp_mask(input tri_t t, input smp_t s,
                                                input logic [LANES-1:0] sv, input logic [1:0] mode);
    logic [LANES-1:0] m;
    int x[3], y[3], d[3];
    logic [SIGFIG-1:0] dv;
    logic back, front;
    for (int l = 0; l < LANES; l++) begin
      for (int v = 0; v < 3; v++) begin
        dv = t[v][0] - s[l][0]; x[v] = trn(dv);
        dv = t[v][1] - s[l][1]; y[v] = trn(dv);
      end
      for (int k = 0; k < 3; k++) begin
        d[k] = int'(longint'(x[k]) * longint'(y[(k+1)%3]) - longint'(x[(k+1)%3]) * longint'(y[k]));
      end
      back  = (d[0] <= 0) && (d[1] < 0) && (d[2] <= 0);
      front = (d[0] >= 0) && (d[1] > 0) && (d[2] >= 0);
      if (mode == 2'd2)      m[l] = front && sv[l];
      else if (mode == 2'd0) m[l] = (back || front) && sv[l];
      else                   m[l] = back && sv[l];
    end
    return m;
  endfunction

  function automatic hit_t exp_hit(input tri_t t, input smp_t s);
    hit_t h;
    for (int l = 0; l < LANES; l++) begin
      h[l][0] = s[l][0];
      h[l][1] = s[l][1];
      h[l][2] = t[0][2];
    end
    return h;
  endfunction

  function automatic tri_t mk_tri(input int x0, input int y0, input int x1, input int y1,
                                  input int x2, input int y2, input int z);
    tri_t t;
    t[0][0] = SIGFIG'(x0); t[0][1] = SIGFIG'(y0); t[0][2] = SIGFIG'(z);
    t[1][0] = SIGFIG'(x1); t[1][1] = SIGFIG'(y1); t[1][2] = SIGFIG'(z + 1);
    t[2][0] = SIGFIG'(x2); t[2][1] = SIGFIG'(y2); t[2][2] = SIGFIG'(z + 2);
    return t;
  endfunction

  function automatic smp_t mk_smp(input int a0, input int b0, input int a1, input int b1,
                                  input int a2, input int b2, input int a3, input int b3);
    smp_t s;
    s[0][0] = SIGFIG'(a0); s[0][1] = SIGFIG'(b0);
    s[1][0] = SIGFIG'(a1); s[1][1] = SIGFIG'(b1);
    s[2][0] = SIGFIG'(a2); s[2][1] = SIGFIG'(b2);
    s[3][0] = SIGFIG'(a3); s[3][1] = SIGFIG'(b3);
    return s;
  endfunction

  function automatic int rc(input bit wide);
    if (wide) return int'($urandom_range(0, 16777215));
    return int'($urandom_range(0, 12000)) - 6000;
  endfunction

  // Scoreboard, hold-stability and counter model, evaluated away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      if (hold_prev) check_val("hold_stable", {out_valid_o, hit_mask_o, hit_o, color_o}, hold_val);
      check_val("cnt", hit_count_o, cnt_m);
      check_val("cnt_c4", hit_count_c4, cnt4_m);
      if (clr_cnt_i) begin
        cnt_m = 0;
        cnt4_m = 0;
      end
      if (out_valid_o && out_ready_i) begin
        if (sb_q.size() == 0) begin
          check_val("stale_out", 1, 0);
        end else begin
          ev = sb_q.pop_front();
          check_val("mask", hit_mask_o, ev.mask);
          check_val("hit", hit_o, ev.hit);
          check_val("color", color_o, ev.col);
          if (!clr_cnt_i) begin
            cnt_m = cnt_m + $countones(ev.mask);
            if (cnt_m > 64'hFFFF_FFFF) cnt_m = 64'hFFFF_FFFF;
            cnt4_m = cnt4_m + $countones(ev.mask);
            if (cnt4_m > 15) cnt4_m = 15;
          end
        end
      end
      hold_prev = out_valid_o && !out_ready_i;
      if (hold_prev) begin
        check_val("ready_low", in_ready_o, 0);
        hold_val = {out_valid_o, hit_mask_o, hit_o, color_o};
      end
      if (in_valid_i && in_ready_o) begin
        ev.mask = exp_mask(tri_i, sample_i, samp_valid_i, cull_mode_i);
        ev.hit  = exp_hit(tri_i, sample_i);
        ev.col  = color_i;
        sb_q.push_back(ev);
      end
    end
  end

  task automatic send(input tri_t t, input smp_t s, input logic [LANES-1:0] sv, input logic [1:0] mode);
    logic ok;
    ok = 1'b0;
    tri_i = t; sample_i = s; samp_valid_i = sv; cull_mode_i = mode;
    color_i = {SIGFIG'($urandom()), SIGFIG'($urandom()), SIGFIG'($urandom())};
    in_valid_i = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); ok = in_ready_o;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) check_val("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    in_valid_i = 1'b0;
    for (int n = 0; n < 50 && sb_q.size() != 0; n++) @(posedge clk);
    check_val("drain", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  tri_t t0, t1, tdeg;
  smp_t s_plan, s_in;
  longint cnt_before;

  initial begin
    #200000;
    check_val("global_timeout", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; clr_cnt_i = 1'b0;
    tri_i = '0; color_i = '0; sample_i = '0; samp_valid_i = '0; cull_mode_i = 2'd0;
    repeat (3) @(posedge clk); #1;
    check_val("rst_valid", out_valid_o, 0);
    check_val("rst_mask", hit_mask_o, 0);
    check_val("rst_hit", hit_o, 0);
    check_val("rst_color", color_o, 0);
    check_val("rst_cnt", hit_count_o, 0);
    check_val("rst_ready", in_ready_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    t0 = mk_tri(0, 0, 0, 4096, 4096, 0, 777);
    t1 = mk_tri(0, 0, 4096, 0, 0, 4096, 555);
    s_plan = mk_smp(1024, 1024, 5120, 5120, 0, 2048, 2048, 0);
    s_in   = mk_smp(512, 512, 1024, 512, 512, 1024, 1024, 1024);

    // plan vector plus exact latency
    send(t0, s_plan, 4'b1111, 2'd1);
    in_valid_i = 1'b0;
    @(negedge clk); check_val("lat1", out_valid_o, 0);
    @(negedge clk); check_val("lat2", out_valid_o, 1);
    check_val("plan_lane0", hit_mask_o[0], 1);
    check_val("plan_lane1", hit_mask_o[1], 0);
    drain();

    // winding vs cull mode
    send(t1, s_plan, 4'b1111, 2'd1);
    send(t1, s_plan, 4'b1111, 2'd2);
    send(t1, s_plan, 4'b1111, 2'd0);
    send(t0, s_plan, 4'b1111, 2'd0);
    send(t0, s_plan, 4'b1111, 2'd2);
    send(t0, s_plan, 4'b1111, 2'd3);
    drain();

    // per-lane valid gating, counter +3
    cnt_before = cnt_m;
    send(t0, s_in, 4'b1110, 2'd1);
    drain();
    check_val("cnt_plus3", hit_count_o, cnt_before + 3);

    // degenerate triangle and truncation-heavy random triangles
    tdeg = mk_tri(100, 100, 100, 100, 100, 100, 9);
    send(tdeg, s_in, 4'b1111, 2'd0);
    for (int i = 0; i < 8; i++) begin
      send(mk_tri(rc(i[0]), rc(i[0]), rc(i[0]), rc(i[0]), rc(i[0]), rc(i[0]), rc(1'b1)),
           mk_smp(rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0)),
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end
    drain();

    // backpressure window
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(mk_tri(rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0), i),
               mk_smp(rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0), rc(1'b0)),
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
        in_valid_i = 1'b0;
      end
      begin
        repeat (3) @(posedge clk); #1 out_ready_i = 1'b0;
        repeat (3) @(posedge clk); #1 out_ready_i = 1'b1;
      end
    join
    drain();

    // saturation on the 4-bit instance
    clr_cnt_i = 1'b1; @(posedge clk); #1 clr_cnt_i = 1'b0;
    send(t0, s_in, 4'b1111, 2'd1);
    send(t0, s_in, 4'b1111, 2'd1);
    send(t0, s_in, 4'b1111, 2'd1);
    send(t0, s_in, 4'b0111, 2'd1);
    drain();
    check_val("sat_pre", hit_count_c4, 15);
    send(t0, s_in, 4'b0001, 2'd1);
    drain();
    check_val("sat_hold", hit_count_c4, 15);
    check_val("cnt_16", hit_count_o, 16);

    // clear coinciding with a hit handshake
    send(t0, s_in, 4'b1111, 2'd1);
    in_valid_i = 1'b0;
    @(posedge clk); #1 clr_cnt_i = 1'b1;
    @(posedge clk); #1 clr_cnt_i = 1'b0;
    @(negedge clk);
    check_val("clr_wins", hit_count_o, 0);
    check_val("clr_wins_c4", hit_count_c4, 0);
    drain();

    // async reset with two beats in flight
    send(t0, s_in, 4'b1111, 2'd1);
    send(t0, s_in, 4'b1111, 2'd1);
    in_valid_i = 1'b0;
    rst = 1'b0;
    sb_q.delete(); cnt_m = 0; cnt4_m = 0; hold_prev = 1'b0;
    #1;
    check_val("rst_async_valid", out_valid_o, 0);
    check_val("rst_async_cnt", hit_count_o, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk); #1;
    check_val("post_rst_valid", out_valid_o, 0);
    check_val("post_rst_cnt", hit_count_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
